// File: rtl/optical_rx_buffer_if.sv
// AXI4-Stream bundle used on both sides of the optical receive buffer.
// The master drives the payload and valid; the slave answers with ready.
interface optical_rx_buffer_if #(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 128
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [TUSER_WIDTH-1:0]  tuser;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  modport master (output tdata, output tstrb, output tuser, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tstrb, input tuser, input tvalid, input tlast, output tready);
endinterface

// File: rtl/optical_rx_buffer.sv
// Store-and-forward receive buffer for the optical port. Ingress cannot be
// back-pressured, so every beat is taken; packets that do not fit (data
// buffer or descriptor queue) are discarded whole and counted. Only fully
// committed packets are released on the egress stream.
module optical_rx_buffer #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int BUFFER_DEPTH_BITS    = 6,
  parameter int META_DEPTH_BITS      = 3
) (
  input  logic                axi_aclk,
  input  logic                axi_aresetn,
  optical_rx_buffer_if.slave  s_axis,
  optical_rx_buffer_if.master m_axis,
  output logic [31:0]         rx_pkt_count,
  output logic [31:0]         rx_drop_count
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int WW = DW + SW + 1;          // {tlast, tstrb, tdata}
  localparam int BB = BUFFER_DEPTH_BITS;
  localparam int MB = META_DEPTH_BITS;

  localparam logic [BB:0]   BUF_DEPTH  = {1'b1, {BB{1'b0}}};
  localparam logic [BB:0]   BUF_ONE    = {{BB{1'b0}}, 1'b1};
  localparam logic [BB-1:0] ADDR_ONE   = {{(BB-1){1'b0}}, 1'b1};
  localparam logic [MB:0]   META_DEPTH = {1'b1, {MB{1'b0}}};
  localparam logic [MB:0]   META_ONE   = {{MB{1'b0}}, 1'b1};

  localparam logic [1:0] WR_IDLE  = 2'd0;
  localparam logic [1:0] WR_WRITE = 2'd1;
  localparam logic [1:0] WR_DROP  = 2'd2;
  localparam logic [0:0] RD_IDLE  = 1'b0;
  localparam logic [0:0] RD_SEND  = 1'b1;

  // Storage: no reset so both map onto block RAM.
  logic [WW-1:0] buf_mem  [0:(1<<BB)-1];
  logic [UW-1:0] meta_mem [0:(1<<MB)-1];

  // Write side state
  logic [1:0]    wr_state_reg, wr_state_next;
  logic [BB:0]   wr_spec_reg, wr_spec_next;
  logic [BB:0]   wr_commit_reg, wr_commit_next;
  logic [UW-1:0] tuser_latch_reg, tuser_latch_next;
  logic [MB:0]   meta_wr_reg;
  logic [31:0]   rx_pkt_count_reg, rx_drop_count_reg;

  // Read side state
  logic [0:0]    rd_state_reg, rd_state_next;
  logic [BB:0]   rd_reg, rd_next;
  logic [MB:0]   meta_rd_reg, meta_rd_next;
  logic          out_valid_reg, out_valid_next;
  logic [WW-1:0] out_word_reg;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] out_tuser_reg;

  logic          beat;
  logic          buf_full, meta_full, meta_empty;
  logic          do_write, do_commit, do_drop;
  logic [UW-1:0] commit_tuser;
  logic          rd_load, tuser_load, out_clear;
  logic [BB-1:0] rd_addr;

  // Ingress is always ready once out of reset.
  assign s_axis.tready = axi_aresetn;
  assign beat          = s_axis.tvalid & s_axis.tready;

  // Occupancy uses registered pointers only: space freed by a read this
  // cycle becomes visible to the writer next cycle.
  assign buf_full   = ((wr_spec_reg - rd_reg) == BUF_DEPTH);
  assign meta_full  = ((meta_wr_reg - meta_rd_reg) == META_DEPTH);
  assign meta_empty = (meta_wr_reg == meta_rd_reg);

  // Write FSM next-state: store speculatively, commit on tlast, rewind on overflow.
  always_comb begin
    wr_state_next    = wr_state_reg;
    wr_spec_next     = wr_spec_reg;
    wr_commit_next   = wr_commit_reg;
    tuser_latch_next = tuser_latch_reg;
    commit_tuser     = tuser_latch_reg;
    do_write         = 1'b0;
    do_commit        = 1'b0;
    do_drop          = 1'b0;
    case (wr_state_reg)
      WR_IDLE: begin
        if (beat) begin
          if (meta_full) begin
            if (s_axis.tlast) do_drop = 1'b1;
            else              wr_state_next = WR_DROP;
          end else if (buf_full) begin
            wr_spec_next = wr_commit_reg;
            if (s_axis.tlast) do_drop = 1'b1;
            else              wr_state_next = WR_DROP;
          end else begin
            do_write         = 1'b1;
            wr_spec_next     = wr_spec_reg + BUF_ONE;
            tuser_latch_next = s_axis.tuser;
            if (s_axis.tlast) begin
              do_commit    = 1'b1;
              commit_tuser = s_axis.tuser;
            end else begin
              wr_state_next = WR_WRITE;
            end
          end
        end
      end
      WR_WRITE: begin
        if (beat) begin
          if (buf_full) begin
            wr_spec_next = wr_commit_reg;
            if (s_axis.tlast) begin
              do_drop       = 1'b1;
              wr_state_next = WR_IDLE;
            end else begin
              wr_state_next = WR_DROP;
            end
          end else begin
            do_write     = 1'b1;
            wr_spec_next = wr_spec_reg + BUF_ONE;
            if (s_axis.tlast) begin
              do_commit     = 1'b1;
              wr_state_next = WR_IDLE;
            end
          end
        end
      end
      WR_DROP: begin
        if (beat && s_axis.tlast) begin
          do_drop       = 1'b1;
          wr_spec_next  = wr_commit_reg;
          wr_state_next = WR_IDLE;
        end
      end
      default: wr_state_next = WR_IDLE;
    endcase
    if (do_commit) wr_commit_next = wr_spec_next;
  end

  // Write-side registers and saturating packet/drop counters.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_state_reg      <= WR_IDLE;
      wr_spec_reg       <= '0;
      wr_commit_reg     <= '0;
      tuser_latch_reg   <= '0;
      meta_wr_reg       <= '0;
      rx_pkt_count_reg  <= '0;
      rx_drop_count_reg <= '0;
    end else begin
      wr_state_reg    <= wr_state_next;
      wr_spec_reg     <= wr_spec_next;
      wr_commit_reg   <= wr_commit_next;
      tuser_latch_reg <= tuser_latch_next;
      if (do_commit) begin
        meta_wr_reg <= meta_wr_reg + META_ONE;
        if (rx_pkt_count_reg != 32'hFFFF_FFFF) rx_pkt_count_reg <= rx_pkt_count_reg + 32'd1;
      end
      if (do_drop && rx_drop_count_reg != 32'hFFFF_FFFF) rx_drop_count_reg <= rx_drop_count_reg + 32'd1;
    end
  end

  // RAM writes: data beat at the speculative pointer, descriptor at commit.
  always_ff @(posedge axi_aclk) begin
    if (do_write)  buf_mem[wr_spec_reg[BB-1:0]]  <= {s_axis.tlast, s_axis.tstrb, s_axis.tdata};
    if (do_commit) meta_mem[meta_wr_reg[MB-1:0]] <= commit_tuser;
  end

  // Read FSM next-state: prefetch the first beat on entry, the following beat on each handshake.
  always_comb begin
    rd_state_next  = rd_state_reg;
    rd_next        = rd_reg;
    meta_rd_next   = meta_rd_reg;
    out_valid_next = out_valid_reg;
    rd_load        = 1'b0;
    tuser_load     = 1'b0;
    out_clear      = 1'b0;
    rd_addr        = rd_reg[BB-1:0];
    case (rd_state_reg)
      RD_IDLE: begin
        if (!meta_empty) begin
          rd_state_next  = RD_SEND;
          out_valid_next = 1'b1;
          rd_load        = 1'b1;
          tuser_load     = 1'b1;
        end
      end
      RD_SEND: begin
        if (m_axis.tready) begin
          rd_next = rd_reg + BUF_ONE;
          if (out_word_reg[WW-1]) begin
            meta_rd_next   = meta_rd_reg + META_ONE;
            rd_state_next  = RD_IDLE;
            out_valid_next = 1'b0;
            out_clear      = 1'b1;
          end else begin
            rd_load = 1'b1;
            rd_addr = rd_reg[BB-1:0] + ADDR_ONE;
          end
        end
      end
      default: rd_state_next = RD_IDLE;
    endcase
  end

  // Read-side registers, including the registered RAM read feeding the egress port.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      rd_state_reg  <= RD_IDLE;
      rd_reg        <= '0;
      meta_rd_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_word_reg  <= '0;
      out_tuser_reg <= '0;
    end else begin
      rd_state_reg  <= rd_state_next;
      rd_reg        <= rd_next;
      meta_rd_reg   <= meta_rd_next;
      out_valid_reg <= out_valid_next;
      if (rd_load)        out_word_reg       <= buf_mem[rd_addr];
      else if (out_clear) out_word_reg[WW-1] <= 1'b0;
      if (tuser_load)     out_tuser_reg      <= meta_mem[meta_rd_reg[MB-1:0]];
    end
  end

  assign m_axis.tvalid = out_valid_reg;
  assign m_axis.tdata  = out_word_reg[C_M_AXIS_DATA_WIDTH-1:0];
  assign m_axis.tstrb  = out_word_reg[DW +: C_M_AXIS_DATA_WIDTH/8];
  assign m_axis.tlast  = out_word_reg[WW-1];
  assign m_axis.tuser  = out_tuser_reg;
  assign rx_pkt_count  = rx_pkt_count_reg;
  assign rx_drop_count = rx_drop_count_reg;

endmodule

// File: tb/tb_optical_rx_buffer.sv
// Directed and randomised bench for optical_rx_buffer. Beat contents are a
// pure function of (packet id, beat index); a monitor checks every egress
// handshake against the list of packets expected to be released.
module tb_optical_rx_buffer;
  localparam int DW = 256;
  localparam int UW = 128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rx_pkt_count, rx_drop_count;

  optical_rx_buffer_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) s_if ();
  optical_rx_buffer_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) m_if ();

  optical_rx_buffer #(
    .C_M_AXIS_DATA_WIDTH(DW), .C_S_AXIS_DATA_WIDTH(DW),
    .C_M_AXIS_TUSER_WIDTH(UW), .C_S_AXIS_TUSER_WIDTH(UW),
    .BUFFER_DEPTH_BITS(6), .META_DEPTH_BITS(3)
  ) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .s_axis(s_if), .m_axis(m_if),
    .rx_pkt_count(rx_pkt_count), .rx_drop_count(rx_drop_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [UW-1:0] tuser; int len; } pkt_t;
  typedef struct { int len; logic [UW-1:0] tuser; bit exp_commit; int exp_pkts; int exp_drops; } vec_t;

  pkt_t sent[$];
  int   exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   out_pkts = 0;
  int   exp_out = 0;
  bit   allow_skip = 1'b0;
  bit   rand_ready = 1'b0;
  int   mon_id, mon_beat;

  function automatic logic [DW-1:0] gen_data(input int id, input int b);
    logic [DW-1:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = 32'(id) * 32'h9E37_79B9 + 32'(b) * 32'h85EB_CA6B + 32'(i);
    return d;
  endfunction

  function automatic logic [DW/8-1:0] gen_strb(input int id, input int b);
    return (32'(id) * 32'h0100_0193) ^ (32'(b) * 32'h27D4_EB2F);
  endfunction

  function automatic int new_pkt(input int len, input logic [UW-1:0] tu);
    pkt_t p;
    p.tuser = tu;
    p.len   = len;
    sent.push_back(p);
    return sent.size() - 1;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive n_beats of packet id; fewer than its length leaves it unfinished.
  task automatic send_pkt(input int id, input int n_beats);
    for (int b = 0; b < n_beats; b++) begin
      @(posedge clk); #1;
      s_if.tvalid = 1'b1;
      s_if.tdata  = gen_data(id, b);
      s_if.tstrb  = gen_strb(id, b);
      s_if.tuser  = (b == 0) ? sent[id].tuser : ~sent[id].tuser;
      s_if.tlast  = (b == sent[id].len - 1);
    end
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while ((out_pkts != exp_out || m_if.tvalid) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(name, 256'(out_pkts), 256'(exp_out));
  endtask

  task automatic check_counts(input string name, input int pkts, input int drops);
    check({name, "_pkt_count"}, 256'(rx_pkt_count), 256'(pkts));
    check({name, "_drop_count"}, 256'(rx_drop_count), 256'(drops));
  endtask

  // One-cycle reset pulse, checking reset values while it is asserted.
  task automatic do_reset(input string name);
    @(posedge clk); #1;
    rst_n = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    @(negedge clk);
    check({name, "_s_tready"}, 256'(s_if.tready), 256'(0));
    check({name, "_m_tvalid"}, 256'(m_if.tvalid), 256'(0));
    check({name, "_m_tlast"}, 256'(m_if.tlast), 256'(0));
    check({name, "_m_tdata"}, m_if.tdata, 256'(0));
    check({name, "_m_tuser"}, 256'(m_if.tuser), 256'(0));
    check_counts(name, 0, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check({name, "_s_tready_after"}, 256'(s_if.tready), 256'(1));
  endtask

  // Egress monitor: every handshake beat is compared with the expected packet.
  initial begin
    mon_id   = -1;
    mon_beat = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_id   = -1;
        mon_beat = 0;
      end else if (m_if.tvalid && m_if.tready) begin
        if (mon_beat == 0) begin
          if (allow_skip)
            while (exp_q.size() > 0 && sent[exp_q[0]].tuser !== m_if.tuser) exp_q.delete(0);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_egress: got tuser %0h expected no packet", m_if.tuser);
            mon_id = -1;
          end else begin
            mon_id = exp_q.pop_front();
          end
        end
        if (mon_id >= 0) begin
          check($sformatf("egress_tuser_p%0d_b%0d", mon_id, mon_beat), 256'(m_if.tuser), 256'(sent[mon_id].tuser));
          check($sformatf("egress_tdata_p%0d_b%0d", mon_id, mon_beat), m_if.tdata, gen_data(mon_id, mon_beat));
          check($sformatf("egress_tstrb_p%0d_b%0d", mon_id, mon_beat), 256'(m_if.tstrb), 256'(gen_strb(mon_id, mon_beat)));
          check($sformatf("egress_tlast_p%0d_b%0d", mon_id, mon_beat), 256'(m_if.tlast), 256'(mon_beat == sent[mon_id].len - 1));
        end
        if (m_if.tlast) begin
          mon_beat = 0;
          out_pkts++;
          $display("egress packet %0d done", mon_id);
        end else begin
          mon_beat++;
        end
      end
    end
  end

  // Random egress back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) m_if.tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: got no end of test, expected completion within 80000 cycles");
    $fatal(1, "simulation stalled");
  end

  initial begin
    vec_t vecs[6];
    int   id, lat, base, idle, k;

    vecs[0] = '{len: 3,  tuser: 128'hA5,    exp_commit: 1'b1, exp_pkts: 1, exp_drops: 0};
    vecs[1] = '{len: 1,  tuser: 128'h1234,  exp_commit: 1'b1, exp_pkts: 2, exp_drops: 0};
    vecs[2] = '{len: 64, tuser: 128'hB00,   exp_commit: 1'b1, exp_pkts: 3, exp_drops: 0};
    vecs[3] = '{len: 65, tuser: 128'hB01,   exp_commit: 1'b0, exp_pkts: 3, exp_drops: 1};
    vecs[4] = '{len: 70, tuser: 128'hB02,   exp_commit: 1'b0, exp_pkts: 3, exp_drops: 2};
    vecs[5] = '{len: 5,  tuser: 128'hC5,    exp_commit: 1'b1, exp_pkts: 4, exp_drops: 2};

    s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0; s_if.tstrb = '0; s_if.tuser = '0;
    m_if.tready = 1'b1;

    // Power-on reset values.
    repeat (3) @(negedge clk);
    check("por_s_tready", 256'(s_if.tready), 256'(0));
    check("por_m_tvalid", 256'(m_if.tvalid), 256'(0));
    check("por_m_tdata", m_if.tdata, 256'(0));
    check_counts("por", 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("por_s_tready_after", 256'(s_if.tready), 256'(1));

    // Table: tready=1, each packet drains before the next one.
    for (int v = 0; v < 6; v++) begin
      id = new_pkt(vecs[v].len, vecs[v].tuser);
      if (vecs[v].exp_commit) begin
        exp_q.push_back(id);
        exp_out++;
      end
      send_pkt(id, vecs[v].len);
      if (vecs[v].exp_commit) begin
        lat = 0;
        while (!m_if.tvalid && lat < 20) begin
          @(negedge clk);
          lat++;
        end
        check($sformatf("vec%0d_latency", v), 256'(lat), 256'(2));
      end
      wait_drain($sformatf("vec%0d_drain", v));
      check_counts($sformatf("vec%0d", v), vecs[v].exp_pkts, vecs[v].exp_drops);
      $display("vector %0d: len %0d pkts %0d drops %0d", v, vecs[v].len, rx_pkt_count, rx_drop_count);
    end

    // Oversized packet with egress stalled, then a small packet held and released.
    do_reset("rstA");
    @(posedge clk); #1; m_if.tready = 1'b0;
    id = new_pkt(70, 128'h7070);
    send_pkt(id, 70);
    repeat (4) @(negedge clk);
    check_counts("big_drop", 0, 1);
    check("big_drop_no_egress", 256'(m_if.tvalid), 256'(0));
    id = new_pkt(4, 128'h4444);
    exp_q.push_back(id);
    send_pkt(id, 4);
    repeat (4) @(negedge clk);
    check_counts("after_big", 1, 1);
    check("hold_tvalid", 256'(m_if.tvalid), 256'(1));
    check("hold_tdata", m_if.tdata, gen_data(id, 0));
    @(posedge clk); #1; m_if.tready = 1'b1;
    exp_out++;
    wait_drain("after_big_drain");

    // Descriptor queue overflow: 9 single-beat packets while stalled.
    do_reset("rstB");
    @(posedge clk); #1; m_if.tready = 1'b0;
    for (int p = 0; p < 9; p++) begin
      id = new_pkt(1, 128'h900 + 128'(p));
      if (p < 8) exp_q.push_back(id);
      send_pkt(id, 1);
    end
    repeat (2) @(negedge clk);
    check_counts("meta_full", 8, 1);
    @(posedge clk); #1; m_if.tready = 1'b1;
    exp_out += 8;
    wait_drain("meta_full_drain");

    // Reset in the middle of a 10-beat packet, then a clean packet.
    id = new_pkt(10, 128'hAAAA);
    send_pkt(id, 5);
    do_reset("rstC");
    id = new_pkt(6, 128'h6666);
    exp_q.push_back(id);
    exp_out++;
    send_pkt(id, 6);
    wait_drain("post_reset_drain");
    check_counts("post_reset", 1, 0);

    // Random lengths with random back-pressure; drops are allowed anywhere.
    do_reset("rstD");
    base = out_pkts;
    allow_skip = 1'b1;
    rand_ready = 1'b1;
    for (int p = 0; p < 200; p++) begin
      int len;
      len = $urandom_range(1, 20);
      id = new_pkt(len, {32'(p), 32'(len), 64'hC0FF_EE00_0000_0000});
      exp_q.push_back(id);
      send_pkt(id, len);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rand_ready = 1'b0;
    @(posedge clk); #2; m_if.tready = 1'b1;
    idle = 0;
    k = 0;
    while (idle < 4 && k < 5000) begin
      @(negedge clk);
      idle = m_if.tvalid ? 0 : idle + 1;
      k++;
    end
    check("random_idle", 256'(idle), 256'(4));
    check("random_total", 256'(rx_pkt_count + rx_drop_count), 256'(200));
    check("random_egress_count", 256'(out_pkts - base), 256'(rx_pkt_count));
    $display("random: committed %0d dropped %0d", rx_pkt_count, rx_drop_count);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
